// File: rtl/risc_v_trace_capture.sv
// risc_v_trace_capture: captures {PC, instruction, ALU result} records from a
// core into a small FIFO after an arm request, then drains them to a consumer.
// Optional macro TRACE_TRIGGER_EN: when defined, capture waits for PC_out to
// match trig_pc; otherwise capture starts in the cycle after arm.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | waiting for trigger; first record pushed when it fires
// CAPTURE | one record per cycle until remaining reaches zero
// DRAIN   | waiting for the consumer to empty the FIFO, then pulse done
module risc_v_trace_capture #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       PC_out,
  input  logic [31:0]      INS_out,
  input  logic [63:0]      ALU_Result,
  input  logic             arm,
  input  logic             abort,
  input  logic [8:0]       trig_pc,
  input  logic [LEN_W-1:0] capture_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [104:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [LEN_W-1:0] remaining;
  logic [104:0]     mem [DEPTH];
  logic             trigger, push_req, load_len, done_nxt;
  logic             full, pop, push;

`ifdef TRACE_TRIGGER_EN
  assign trigger = (PC_out == trig_pc);
`else
  logic unused_trig_pc;
  assign unused_trig_pc = ^trig_pc;
  assign trigger = 1'b1;
`endif

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes; abort overrides everything.
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    load_len  = 1'b0;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            load_len  = 1'b1;
            state_nxt = (capture_len == '0) ? DRAIN : ARMED;
          end
        end
        ARMED: begin
          if (trigger) begin
            push_req  = 1'b1;
            state_nxt = (remaining <= LEN_W'(1)) ? DRAIN : CAPTURE;
          end
        end
        CAPTURE: begin
          push_req = 1'b1;
          if (remaining <= LEN_W'(1)) state_nxt = DRAIN;
        end
        DRAIN: begin
          if (count == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy, remaining-record counter and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_nxt;
      if (abort) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        remaining <= '0;
      end else begin
        if (load_len) begin
          remaining <= capture_len;
          overflow  <= 1'b0;
        end else if (push_req) begin
          // Counts down whether the record was stored or dropped.
          remaining <= remaining - LEN_W'(1);
        end
        if (push_req && !push) overflow <= 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  // Record storage; contents are don't-care while out_valid is low.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {PC_out, INS_out, ALU_Result};
  end

endmodule
